// File: rtl/stagger_issue_buffer_pkg.sv
// Shared definitions for the stagger issue buffer.
//   stagger_state_t : controller states (IDLE, LOADING, ISSUING, DONE)
//   TS_WIDTH        : width of a timestep index (supports up to 32 timesteps)
//   idx_width()     : address width for an array of a given depth (minimum 1)
package stagger_issue_buffer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOADING = 2'd1,
        ISSUING = 2'd2,
        DONE    = 2'd3
    } stagger_state_t;

    localparam int TS_WIDTH = 5;

    // Address width for an array of 'depth' entries; a single-entry array still needs one bit.
    function automatic int idx_width(input int depth);
        if (depth > 1) begin
            return $clog2(depth);
        end else begin
            return 1;
        end
    endfunction

endpackage

// File: rtl/stagger_issue_buffer_if.sv
// Bus between a vector producer and the stagger issue buffer.
//   vec_valid/vec_ready/vec_in : one full NUM_NEURONS-wide vector per handshake
//   lane_out/lane_valid/lane_ts: skewed per-lane issue stream
//   first_out/busy/done        : status toward the downstream layer
// Modports: master = producer/consumer side, slave = the buffer itself.
interface stagger_issue_buffer_if #(
    parameter int NUM_NEURONS = 16,
    parameter int DATA_WIDTH  = 24
);
    import stagger_issue_buffer_pkg::*;

    logic                         vec_valid;
    logic                         vec_ready;
    logic signed [DATA_WIDTH-1:0] vec_in     [0:NUM_NEURONS-1];
    logic signed [DATA_WIDTH-1:0] lane_out   [0:NUM_NEURONS-1];
    logic [NUM_NEURONS-1:0]       lane_valid;
    logic [TS_WIDTH-1:0]          lane_ts    [0:NUM_NEURONS-1];
    logic                         first_out;
    logic                         busy;
    logic                         done;

    modport master (
        output vec_valid, vec_in,
        input  vec_ready, lane_out, lane_valid, lane_ts, first_out, busy, done
    );

    modport slave (
        input  vec_valid, vec_in,
        output vec_ready, lane_out, lane_valid, lane_ts, first_out, busy, done
    );

endinterface

// File: rtl/stagger_issue_buffer.sv
// Stagger issue buffer: stores NUM_TIMESTEPS full vectors, then re-emits them skewed so
// lane n carries timestep t at issue cycle k = t + n (inverse of the output deskew).
// Ports:
//   clk   : clock, all logic on posedge
//   reset : synchronous, active-high; aborts any load/issue in progress
//   bus   : stagger_issue_buffer_if.slave (vector input handshake, lane outputs, status)
module stagger_issue_buffer #(
    parameter int NUM_NEURONS   = 16,
    parameter int NUM_TIMESTEPS = 30,
    parameter int DATA_WIDTH    = 24
) (
    input logic                    clk,
    input logic                    reset,
    stagger_issue_buffer_if.slave  bus
);
    import stagger_issue_buffer_pkg::*;

    localparam int K_W   = $clog2(NUM_NEURONS + NUM_TIMESTEPS);
    // Lane index math is done at a width that holds both k and a timestep index.
    localparam int IDX_W = (K_W > TS_WIDTH) ? K_W : TS_WIDTH;
    localparam int AW    = idx_width(NUM_TIMESTEPS);

    localparam logic [K_W-1:0]      K_ZERO  = K_W'(0);
    localparam logic [K_W-1:0]      K_ONE   = K_W'(1);
    localparam logic [K_W-1:0]      K_LAST  = K_W'(NUM_NEURONS + NUM_TIMESTEPS - 2);
    localparam logic [TS_WIDTH-1:0] TS_ZERO = TS_WIDTH'(0);
    localparam logic [TS_WIDTH-1:0] TS_ONE  = TS_WIDTH'(1);
    localparam logic [TS_WIDTH-1:0] TS_LAST = TS_WIDTH'(NUM_TIMESTEPS - 1);
    localparam logic [IDX_W-1:0]    IDX_T   = IDX_W'(NUM_TIMESTEPS);

    stagger_state_t               state_r;
    logic [TS_WIDTH-1:0]          ts_count_r;
    logic [K_W-1:0]               k_r;
    logic                         done_r;
    logic signed [DATA_WIDTH-1:0] storage_r [0:NUM_TIMESTEPS-1][0:NUM_NEURONS-1];

    logic                         vec_ready_s;
    logic                         accept_s;
    logic                         busy_s;
    logic                         first_out_s;
    logic [NUM_NEURONS-1:0]       lane_valid_s;
    logic signed [DATA_WIDTH-1:0] lane_out_s [0:NUM_NEURONS-1];
    logic [TS_WIDTH-1:0]          lane_ts_s  [0:NUM_NEURONS-1];

    assign vec_ready_s = (state_r != ISSUING);
    assign accept_s    = bus.vec_valid & vec_ready_s;

    // Vector storage: the accepted vector lands at the current load slot.
    always_ff @(posedge clk) begin
        if (!reset && accept_s) begin
            storage_r[AW'(ts_count_r)] <= bus.vec_in;
        end
    end

    // Controller: load counter, issue counter k and the sticky done flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= IDLE;
            ts_count_r <= TS_ZERO;
            k_r        <= K_ZERO;
            done_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE, DONE: begin
                    if (accept_s) begin
                        done_r <= 1'b0;
                        // A single-timestep run is fully loaded by its first vector.
                        if (NUM_TIMESTEPS == 1) begin
                            state_r    <= ISSUING;
                            ts_count_r <= TS_ZERO;
                            k_r        <= K_ZERO;
                        end else begin
                            state_r    <= LOADING;
                            ts_count_r <= TS_ONE;
                        end
                    end
                end
                LOADING: begin
                    if (accept_s) begin
                        if (ts_count_r == TS_LAST) begin
                            state_r    <= ISSUING;
                            ts_count_r <= TS_ZERO;
                            k_r        <= K_ZERO;
                        end else begin
                            ts_count_r <= ts_count_r + TS_ONE;
                        end
                    end
                end
                ISSUING: begin
                    if (k_r == K_LAST) begin
                        state_r <= DONE;
                        done_r  <= 1'b1;
                        k_r     <= K_ZERO;
                    end else begin
                        k_r <= k_r + K_ONE;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    ts_count_r <= TS_ZERO;
                    k_r        <= K_ZERO;
                    done_r     <= 1'b0;
                end
            endcase
        end
    end

    // Skewed lane selection: lane n shows timestep k-n while that index lies in [0, T).
    always_comb begin : lane_mux
        logic [IDX_W-1:0] diff_v;
        diff_v      = {IDX_W{1'b0}};
        busy_s      = (state_r == LOADING) || (state_r == ISSUING);
        first_out_s = (state_r == ISSUING) && (k_r == K_ZERO);
        for (int n = 0; n < NUM_NEURONS; n++) begin
            lane_valid_s[n] = 1'b0;
            lane_out_s[n]   = {DATA_WIDTH{1'b0}};
            lane_ts_s[n]    = TS_ZERO;
            // The k >= n guard comes first so the unsigned subtraction never wraps.
            if ((state_r == ISSUING) && (IDX_W'(k_r) >= IDX_W'(n))) begin
                diff_v = IDX_W'(k_r) - IDX_W'(n);
                if (diff_v < IDX_T) begin
                    lane_valid_s[n] = 1'b1;
                    lane_out_s[n]   = storage_r[AW'(diff_v)][n];
                    lane_ts_s[n]    = TS_WIDTH'(diff_v);
                end else begin
                    lane_valid_s[n] = 1'b0;
                end
            end else begin
                lane_valid_s[n] = 1'b0;
            end
        end
    end

    assign bus.vec_ready  = vec_ready_s;
    assign bus.lane_out   = lane_out_s;
    assign bus.lane_valid = lane_valid_s;
    assign bus.lane_ts    = lane_ts_s;
    assign bus.first_out  = first_out_s;
    assign bus.busy       = busy_s;
    assign bus.done       = done_r;

endmodule

// File: tb/tb_stagger_issue_buffer.sv
// Directed self-checking bench for stagger_issue_buffer.
// dut_a: N=4, T=3; dut_b: N=4, T=1. Lane value of timestep t on lane n is 100*t+n
// (optionally negated / offset). Accepted vectors go into a scoreboard queue and are
// popped when the issue phase starts; each issue cycle is checked against them.
module tb_stagger_issue_buffer;
    import stagger_issue_buffer_pkg::*;

    localparam int N  = 4;
    localparam int T  = 3;
    localparam int DW = 24;

    typedef logic [N-1:0][DW-1:0] pvec_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    stagger_issue_buffer_if #(.NUM_NEURONS(N), .DATA_WIDTH(DW)) ifa ();
    stagger_issue_buffer_if #(.NUM_NEURONS(N), .DATA_WIDTH(DW)) ifb ();

    stagger_issue_buffer #(.NUM_NEURONS(N), .NUM_TIMESTEPS(T), .DATA_WIDTH(DW)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa)
    );

    stagger_issue_buffer #(.NUM_NEURONS(N), .NUM_TIMESTEPS(1), .DATA_WIDTH(DW)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb)
    );

    int    n_cmp = 0;
    int    n_mis = 0;
    pvec_t vec_q [$];
    pvec_t cur   [0:T-1];
    bit    loading;
    bit    exp_done;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic pvec_t mkvec(input int t, input int sgn, input int offs);
        pvec_t v;
        for (int n = 0; n < N; n++) begin
            v[n] = DW'(sgn * (100 * t + n) + offs);
        end
        return v;
    endfunction

    task automatic drive_a(input pvec_t v);
        for (int n = 0; n < N; n++) ifa.vec_in[n] = v[n];
    endtask

    task automatic drive_b(input pvec_t v);
        for (int n = 0; n < N; n++) ifb.vec_in[n] = v[n];
    endtask

    // One load-phase cycle on dut_a: check status, then offer (or withhold) a vector.
    task automatic step_a(input bit valid, input int t, input int sgn);
        pvec_t v;
        @(negedge clk);
        chk("load_ready", ifa.vec_ready, 1);
        chk("load_busy", ifa.busy, loading);
        chk("load_done", ifa.done, exp_done);
        chk("load_lane_valid", ifa.lane_valid, 0);
        ifa.vec_valid = valid;
        if (valid) begin
            v = mkvec(t, sgn, 0);
            drive_a(v);
            vec_q.push_back(v);
            loading  = 1'b1;
            exp_done = 1'b0;
        end else begin
            drive_a(mkvec(9, 1, 0));
        end
    endtask

    // Issue phase on dut_a. hold: keep vec_valid high with the next run's first vector.
    // abort_k >= 0: assert reset at that issue cycle and return.
    task automatic issue_a(input bit hold, input int abort_k);
        pvec_t            v;
        logic [N-1:0]     exp_valid;
        logic signed [31:0] eo;
        int               et;
        for (int t = 0; t < T; t++) cur[t] = vec_q.pop_front();
        loading = 1'b0;
        for (int k = 0; k <= N + T - 2; k++) begin
            @(negedge clk);
            if (k == 0) begin
                ifa.vec_valid = hold;
                if (hold) begin
                    v = mkvec(0, -1, 0);
                    drive_a(v);
                    vec_q.push_back(v);
                end
            end
            chk($sformatf("k%0d_first_out", k), ifa.first_out, (k == 0) ? 1 : 0);
            chk($sformatf("k%0d_busy", k), ifa.busy, 1);
            chk($sformatf("k%0d_ready", k), ifa.vec_ready, 0);
            chk($sformatf("k%0d_done", k), ifa.done, 0);
            exp_valid = '0;
            for (int n = 0; n < N; n++) begin
                if (k >= n && (k - n) < T) begin
                    exp_valid[n] = 1'b1;
                    eo = $signed(cur[k - n][n]);
                    et = k - n;
                end else begin
                    eo = 0;
                    et = 0;
                end
                chk($sformatf("k%0d_lane%0d_out", k, n), ifa.lane_out[n], eo);
                chk($sformatf("k%0d_lane%0d_ts", k, n), ifa.lane_ts[n], et);
            end
            chk($sformatf("k%0d_lane_valid", k), ifa.lane_valid, exp_valid);
            if (k == abort_k) begin
                reset = 1'b1;
                return;
            end
        end
        @(negedge clk);
        chk("done_high", ifa.done, 1);
        chk("done_busy", ifa.busy, 0);
        chk("done_ready", ifa.vec_ready, 1);
        chk("done_lane_valid", ifa.lane_valid, 0);
        chk("done_first_out", ifa.first_out, 0);
        exp_done = !hold;
        if (hold) loading = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        pvec_t vb;
        pvec_t curb;
        loading  = 1'b0;
        exp_done = 1'b0;
        reset    = 1'b1;
        // A handshake offered during reset must be ignored.
        ifa.vec_valid = 1'b1;
        drive_a(mkvec(7, 1, 0));
        ifb.vec_valid = 1'b0;
        drive_b(mkvec(0, 1, 0));
        repeat (2) @(negedge clk);
        chk("rst_lane_valid", ifa.lane_valid, 0);
        chk("rst_first_out", ifa.first_out, 0);
        chk("rst_busy", ifa.busy, 0);
        chk("rst_done", ifa.done, 0);
        chk("rst_ready", ifa.vec_ready, 1);
        for (int n = 0; n < N; n++) begin
            chk($sformatf("rst_lane%0d_out", n), ifa.lane_out[n], 0);
            chk($sformatf("rst_lane%0d_ts", n), ifa.lane_ts[n], 0);
        end
        ifa.vec_valid = 1'b0;
        reset = 1'b0;

        // Tests 1+2: back-to-back load, full issue, done held.
        for (int t = 0; t < T; t++) step_a(1'b1, t, 1);
        issue_a(1'b0, -1);
        step_a(1'b0, 0, 1);
        step_a(1'b0, 0, 1);

        // Test 3: gapped load from DONE, valid pattern 1,0,0,1,0,1.
        step_a(1'b1, 0, 1);
        step_a(1'b0, 0, 1);
        step_a(1'b0, 0, 1);
        step_a(1'b1, 1, 1);
        step_a(1'b0, 0, 1);
        step_a(1'b1, 2, 1);
        // Test 4: vec_valid held through issue; accepted only in DONE (negative data).
        issue_a(1'b1, -1);
        step_a(1'b1, 1, -1);
        step_a(1'b1, 2, -1);
        issue_a(1'b0, -1);

        // Test 5: reset at k=2 aborts the issue; a fresh load reissues from timestep 0.
        for (int t = 0; t < T; t++) step_a(1'b1, t, 1);
        issue_a(1'b0, 2);
        @(negedge clk);
        chk("abort_lane_valid", ifa.lane_valid, 0);
        chk("abort_done", ifa.done, 0);
        chk("abort_ready", ifa.vec_ready, 1);
        chk("abort_busy", ifa.busy, 0);
        chk("abort_first_out", ifa.first_out, 0);
        reset    = 1'b0;
        loading  = 1'b0;
        exp_done = 1'b0;
        for (int t = 0; t < T; t++) step_a(1'b1, 2 - t, 1);
        issue_a(1'b0, -1);

        // Test 6: T=1 instance goes straight from one accept to a 4-cycle issue.
        @(negedge clk);
        chk("b_ready", ifb.vec_ready, 1);
        chk("b_busy", ifb.busy, 0);
        vb = mkvec(0, 1, 1000);
        ifb.vec_valid = 1'b1;
        drive_b(vb);
        vec_q.push_back(vb);
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            if (k == 0) begin
                ifb.vec_valid = 1'b0;
                curb = vec_q.pop_front();
            end
            chk($sformatf("b_k%0d_first_out", k), ifb.first_out, (k == 0) ? 1 : 0);
            chk($sformatf("b_k%0d_busy", k), ifb.busy, 1);
            chk($sformatf("b_k%0d_ready", k), ifb.vec_ready, 0);
            chk($sformatf("b_k%0d_lane_valid", k), ifb.lane_valid, 4'b0001 << k);
            for (int n = 0; n < N; n++) begin
                chk($sformatf("b_k%0d_lane%0d_out", k, n), ifb.lane_out[n],
                    (n == k) ? $signed(curb[n]) : 0);
                chk($sformatf("b_k%0d_lane%0d_ts", k, n), ifb.lane_ts[n], 0);
            end
        end
        @(negedge clk);
        chk("b_done", ifb.done, 1);
        chk("b_done_busy", ifb.busy, 0);
        chk("b_done_lane_valid", ifb.lane_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
